// File: rtl/plot_buffer.sv
// Pixel FIFO between the shape drawers and the 160x120 framebuffer port.
// Optional `PLOT_BUF_COALESCE_EN: a repeated write to the newest held address is merged into that entry.
module plot_buffer #(
    parameter int DEPTH    = 16,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 in_x,
    input  logic [6:0]                 in_y,
    input  logic [2:0]                 in_colour,
    input  logic                       in_plot,
    output logic                       in_ready,
    output logic [14:0]                fb_addr,
    output logic [2:0]                 fb_data,
    output logic                       fb_we,
    input  logic                       fb_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                drop_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] VALID = 1'b1;

    typedef struct packed {
        logic [14:0] addr;
        logic [2:0]  colour;
    } pix_t;

    // Storage behind the output register; it never holds more than DEPTH-1 pixels.
    pix_t          mem [DEPTH];
    pix_t          out_q;
    pix_t          pix;
    pix_t          newest;
    logic [0:0]    state;
    logic [PW-1:0] rd_ptr, wr_ptr, wr_last;
    logic [LW-1:0] level_q, level_next;
    logic          on_screen, accept, retire, cand, coal, push, to_out, to_mem, pop;

    assign in_ready = !rst && (level_q != LW'(DEPTH));
    assign fb_we    = (state == VALID);
    assign fb_addr  = out_q.addr;
    assign fb_data  = out_q.colour;
    assign level    = level_q;
    assign wr_last  = wr_ptr - 1'b1;

    always_comb begin
        pix.addr   = ({8'd0, in_y} << 7) + ({8'd0, in_y} << 5) + {7'd0, in_x};
        pix.colour = in_colour;
        on_screen  = (32'(in_x) < SCREEN_W) && (32'(in_y) < SCREEN_H);
        accept     = in_plot && in_ready;
        retire     = fb_we && fb_ready;
        cand       = accept && on_screen;
        newest     = (level_q == LW'(1)) ? out_q : mem[wr_last];
`ifdef PLOT_BUF_COALESCE_EN
        // A newest entry sitting in the output register and leaving this cycle cannot be merged.
        coal = cand && (level_q != '0) && (newest.addr == pix.addr)
               && !((level_q == LW'(1)) && retire);
`else
        coal = 1'b0;
`endif
        push       = cand && !coal;
        to_out     = push && ((level_q == '0) || ((level_q == LW'(1)) && retire));
        to_mem     = push && !to_out;
        pop        = retire && (level_q >= LW'(2));
        level_next = level_q + LW'(push) - LW'(retire);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (to_mem)
                mem[wr_ptr] <= pix;
            if (coal && (level_q >= LW'(2)))
                mem[wr_last].colour <= in_colour;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            level_q    <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            out_q      <= '0;
            drop_count <= '0;
        end else begin
            if (to_mem)
                wr_ptr <= wr_ptr + 1'b1;
            if (coal && (level_q == LW'(1)))
                out_q.colour <= in_colour;
            if (pop) begin
                out_q  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
                // At level 2 the entry being merged is the one moving out right now.
                if (coal && (level_q == LW'(2)))
                    out_q.colour <= in_colour;
            end else if (to_out) begin
                out_q <= pix;
            end
            if (accept && !on_screen && (drop_count != 16'hFFFF))
                drop_count <= drop_count + 16'd1;
            level_q <= level_next;
            state   <= (level_next != '0) ? VALID : EMPTY;
        end
    end
endmodule

// File: tb/tb_plot_buffer.sv
// Randomised and directed bench for plot_buffer against a queue-based pixel model.
module tb_plot_buffer;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_x = '0;
    logic [6:0]  in_y = '0;
    logic [2:0]  in_colour = '0;
    logic        in_plot = 1'b0;
    logic        in_ready;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_we;
    logic        fb_ready = 1'b0;
    logic [4:0]  level;
    logic [15:0] drop_count;

    plot_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
        .in_plot(in_plot), .in_ready(in_ready), .fb_addr(fb_addr), .fb_data(fb_data),
        .fb_we(fb_we), .fb_ready(fb_ready), .level(level), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int colour;
    } mpix_t;

    mpix_t q[$];
    int    m_drop = 0;
    int    m_last_addr = 0;
    int    m_last_col = 0;
    int    writes = 0;
    int    checks = 0;
    int    errors = 0;
    bit    last_accepted;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, compare outputs with the model, then advance the model past the edge.
    task automatic step(input bit p, input int x, input int y, input int c, input bit fr, input bit r);
        bit    rdy, acc, ret, onscr;
        int    a;
        mpix_t e;
        in_plot = p; in_x = 8'(x); in_y = 7'(y); in_colour = 3'(c); fb_ready = fr; rst = r;
        #1;
        rdy = !r && (q.size() < DEPTH);
        chk("in_ready", int'(in_ready), int'(rdy));
        chk("fb_we", int'(fb_we), int'(q.size() > 0));
        chk("level", int'(level), q.size());
        chk("fb_addr", int'(fb_addr), m_last_addr);
        chk("fb_data", int'(fb_data), m_last_col);
        chk("drop_count", int'(drop_count), m_drop);
        @(posedge clk);
        acc = p && rdy;
        last_accepted = acc;
        if (r) begin
            q.delete(); m_drop = 0; m_last_addr = 0; m_last_col = 0;
        end else begin
            ret   = (q.size() > 0) && fr;
            onscr = (x < 160) && (y < 120);
            a     = y * 160 + x;
            if (ret) writes++;
            if (acc && !onscr) begin
                if (m_drop < 65535) m_drop++;
            end
`ifdef PLOT_BUF_COALESCE_EN
            else if (acc && q.size() > 0 && q[$].addr == a && !(q.size() == 1 && ret)) begin
                q[$].colour = c;
                acc = 1'b0;
            end
`endif
            if (ret) void'(q.pop_front());
            if (acc && onscr) begin
                e.addr = a; e.colour = c;
                q.push_back(e);
            end
            if (q.size() > 0) begin
                m_last_addr = q[0].addr; m_last_col = q[0].colour;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && q.size() > 0; i++) step(0, 0, 0, 0, 1, 0);
        chk("drained", q.size(), 0);
    endtask

    initial begin
        int x, y, n, tog;
        @(negedge clk);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("reset_in_ready", int'(in_ready), 1);

        // Single pixel (5,2)
        step(1, 5, 2, 5, 1, 0);
        #1; chk("single_addr", int'(fb_addr), 325); chk("single_data", int'(fb_data), 5);
        step(0, 0, 0, 0, 1, 0);
        chk("single_level", int'(level), 0);

        // Fill with fb_ready low, then release
        n = 0;
        for (int i = 0; i < 20 && n < 20; i++) begin
            step(1, n, 0, n % 8, 0, 0);
            if (last_accepted) n++;
        end
        chk("full_level", int'(level), 16);
        chk("full_in_ready", int'(in_ready), 0);
        for (int k = 0; k < 200 && n < 20; k++) begin
            step(1, n, 0, n % 8, 1, 0);
            if (last_accepted) n++;
        end
        chk("fill_all_taken", n, 20);
        drain();

        // Off-screen and corner
        step(1, 160, 0, 1, 1, 0);
        step(1, 0, 120, 1, 1, 0);
        chk("drop2", int'(drop_count), 2);
        chk("drop_level", int'(level), 0);
        step(1, 159, 119, 6, 1, 0);
        #1; chk("corner_addr", int'(fb_addr), 19199);
        drain();

        // Reset with level 7
        for (int i = 0; i < 7; i++) step(1, i, 3, i, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("rst7_level", int'(level), 0);
        chk("rst7_we", int'(fb_we), 0);
        step(0, 0, 0, 0, 0, 0);

`ifdef PLOT_BUF_COALESCE_EN
        for (int i = 1; i <= 3; i++) step(1, 7, 7, i, 0, 0);
        chk("coal_level", int'(level), 1);
        chk("coal_data", int'(fb_data), 3);
        drain();
`endif

        // Randomised traffic, including duplicate and off-screen pixels
        for (int i = 0; i < 3000; i++) begin
            x = $urandom_range(0, 9) == 0 ? $urandom_range(160, 255) : $urandom_range(0, 159);
            y = $urandom_range(0, 15) == 0 ? $urandom_range(120, 127) : $urandom_range(0, 3);
            step($urandom_range(0, 3) != 0, x, y, $urandom_range(0, 7),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 499) == 0);
        end
        drain();

        // Full-screen fill with fb_ready toggling
        step(0, 0, 0, 0, 0, 1);
        writes = 0; n = 0; tog = 1;
        for (int k = 0; k < 60000 && n < 19200; k++) begin
            step(1, n % 160, n / 160, (n % 160) % 8, tog[0], 0);
            tog ^= 1;
            if (last_accepted) n++;
        end
        drain();
        chk("fill_pixels", n, 19200);
        chk("fill_writes", writes, 19200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
